// File: rtl/spi_mem_master.sv
// SPI initiator for the single-port memory wrapper. Each host request is
// sent as two 11-bit frames (address frame, then data frame) separated by a
// programmable number of SS_n-high gap cycles. Reads capture the data byte
// from MISO during the payload bits of the second frame.
module spi_mem_master #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] LAST_BIT = 4'd10;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_e     state_q,   state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       second_q,  second_d;
    logic       op_q,      op_d;
    logic [7:0] addr_q,    addr_d;
    logic [7:0] wdata_q,   wdata_d;
    logic [6:0] shift_q,   shift_d;
    logic [7:0] rdata_q,   rdata_d;
    logic       ss_n_q,    ss_n_d;
    logic       mosi_q,    mosi_d;
    logic       busy_q,    busy_d;
    logic       done_q,    done_d;

    // Serial bit idx (0 = select bit) of the frame selected by op / frame number.
    // Read-family data frame carries an all-zero payload so MOSI stays low.
    function automatic logic frame_bit(
        input logic       rd,
        input logic       second,
        input logic [7:0] a,
        input logic [7:0] w,
        input logic [3:0] idx
    );
        logic [10:0] word;
        logic [3:0]  pos;
        case ({rd, second})
            2'b00:   word = {1'b1, 2'b00, a};
            2'b01:   word = {1'b1, 2'b01, w};
            2'b10:   word = {1'b0, 2'b10, a};
            2'b11:   word = {1'b0, 2'b11, 8'h00};
            default: word = 11'h000;
        endcase
        if (idx <= LAST_BIT) begin
            pos = LAST_BIT - idx;
            return word[pos];
        end else begin
            return 1'b0;
        end
    endfunction

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        second_d  = second_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        ss_n_d    = 1'b1;
        mosi_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    addr_d    = addr;
                    wdata_d   = wdata;
                    second_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    gap_cnt_d = 4'd0;
                    state_d   = ST_FRAME;
                    ss_n_d    = 1'b0;
                    mosi_d    = frame_bit(op, 1'b0, addr, wdata, 4'd0);
                    busy_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_FRAME: begin
                // Read data arrives on payload bits of the second frame.
                if (second_q && op_q && (bit_cnt_q >= 4'd3)) begin
                    shift_d = {shift_q[5:0], MISO};
                end else begin
                    shift_d = shift_q;
                end

                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = 4'd0;
                    ss_n_d    = 1'b1;
                    if (second_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        if (op_q) begin
                            rdata_d = {shift_q, MISO};
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = 4'd0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    ss_n_d    = 1'b0;
                    mosi_d    = frame_bit(op_q, second_q, addr_q, wdata_q,
                                          bit_cnt_q + 4'd1);
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 4'd0;
                    second_d  = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_FRAME;
                    ss_n_d    = 1'b0;
                    mosi_d    = frame_bit(op_q, 1'b1, addr_q, wdata_q, 4'd0);
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here; only IDLE accepts.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces SS_n high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            gap_cnt_q <= 4'd0;
            second_q  <= 1'b0;
            op_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            shift_q   <= 7'h00;
            rdata_q   <= 8'h00;
            ss_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            second_q  <= second_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            ss_n_q    <= ss_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign SS_n  = ss_n_q;
    assign MOSI  = mosi_q;

endmodule

// File: doc/spi_mem_master.md
# spi_mem_master

SPI master that runs complete write and read transactions against the SPI-attached single-port memory wrapper. Each host request becomes two SPI frames: address then data. The block drives SS_n and MOSI and captures MISO. It sits between on-chip control logic and the memory wrapper's SPI pins, replacing hand-driven serial stimulus with a synthesizable initiator.

## Interface
Parameters:
- GAP_CYCLES, 1: SS_n-high cycles between the two frames of a transaction; legal range 1–15.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request strobe; sampled only when busy=0.
- op  in  1  0 = write, 1 = read; latched with start.
- addr  in  8  memory address; latched with start.
- wdata  in  8  write data; latched with start; ignored for reads.
- busy  out  1  high from the cycle after start acceptance until the done cycle (exclusive).
- done  out  1  one-cycle pulse at transaction end.
- rdata  out  8  read result; updated only at read completion and held otherwise.
- SS_n  out  1  slave select, active-low.
- MOSI  out  1  serial data to slave, MSB first.
- MISO  in  1  serial data from slave, MSB first.

## Operation
- Frame format, 11 cycles with SS_n low:
  - bit 0 is the select bit: 1 for the write family, 0 for the read family.
  - bits 1–2 are CMD[1], CMD[0].
  - bits 3–10 are the payload, MSB first.
- Write transaction:
  - frame A: select 1, CMD 00, payload addr.
  - GAP_CYCLES with SS_n high.
  - frame B: select 1, CMD 01, payload wdata.
- Read transaction:
  - frame A: select 0, CMD 10, payload addr.
  - GAP_CYCLES with SS_n high.
  - frame B: select 0, CMD 11.
  - During B bits 3–10, MOSI=0 and MISO is shifted in MSB first.
- States:
  - IDLE: SS_n=1, MOSI=0.
  - FRAME: 4-bit counter 0..10 plus a second-frame flag.
  - GAP: counter 0..GAP_CYCLES-1.
  - DONE: one cycle; done=1, SS_n=1.
- Transitions:
  - IDLE→FRAME when start=1.
  - FRAME→GAP at bit 10 of frame A.
  - GAP→FRAME when the gap counter expires.
  - FRAME→DONE at bit 10 of frame B.
  - DONE→IDLE.
- start while busy=1: ignored, no queueing.
- start during the DONE cycle: ignored. The block must be in IDLE to accept.
- op, addr and wdata are registered at acceptance. Input changes afterwards have no effect on the transaction in flight.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Reset values, applied asynchronously on rst=1: SS_n=1, MOSI=0, busy=0, done=0, rdata=8'h00, state IDLE, counters 0.
- Reset mid-frame: SS_n rises immediately (asynchronously), and the transaction is abandoned with no done pulse. After rst falls, the block needs a fresh start.
- Cycle numbering: start is sampled at edge E0; cycle n is the interval after edge En.
- Frame A occupies cycles 1–11: SS_n=0, MOSI = frame bit (n-1). busy=1 from cycle 1.
- Gap occupies cycles 12 to 11+GAP_CYCLES.
- Frame B occupies cycles 12+GAP_CYCLES to 22+GAP_CYCLES.
- MISO for a read:
  - Sampled at the rising edge that ends each of frame B bits 3–10.
  - The first sample becomes rdata[7]; the assembled byte is written to rdata at the last sample.
- DONE occupies cycle 23+GAP_CYCLES: done=1, busy=0, rdata valid.
  - With GAP_CYCLES=1, done appears in cycle 24 after acceptance.
- Earliest next acceptance is the edge ending the DONE cycle plus one, i.e. the first IDLE cycle. Back-to-back transactions are therefore separated by at least 2 SS_n-high cycles.
- Width rules:
  - The bit counter never exceeds 10; the gap counter never exceeds GAP_CYCLES-1.
  - No wrap-around is visible on outputs.

## Test plan
- Write: addr=100 (0x64), wdata=11 (0x0B).
  - MOSI cycles 1–11 = 1,0,0,0,1,1,0,0,1,0,0.
  - One SS_n-high gap cycle.
  - MOSI frame B = 1,0,1,0,0,0,0,1,0,1,1.
  - done=1 in cycle 24, with busy high in cycles 1–23 only.
- Read: addr=0xC7 with a MISO model serving 0xA5 during frame B bits 3–10.
  - Frame A MOSI = 0,1,0 followed by 0xC7 MSB first.
  - Frame B MOSI = 0,1,1, then zeros.
  - rdata=0xA5 with done in cycle 24; rdata unchanged afterwards.
- Loopback against the memory wrapper: write addresses 100–199 with data 11,22,…,253 wrapping to 11, then read all 100 back. Required: zero mismatches.
- start pulsed at cycles 5, 15 and the DONE cycle. Required: all ignored; exactly one done and no extra SS_n falling edges.
- rst asserted during frame A bit 6.
  - SS_n=1 and MOSI=0 within the same cycle, busy=0, no done.
  - After release, a write of addr 0x01, data 0xFF completes normally.
- GAP_CYCLES=3 instance: SS_n high for exactly 3 cycles between frames; done in cycle 26.
